// File: rtl/feature_dispatcher_pkg.sv
// Shared constants and types for the feature ingress path.
// The inference cluster reuses VPE_NUM and FEAT_W.
package feature_dispatcher_pkg;

  localparam int VPE_NUM        = 8;
  localparam int FEAT_W         = 256;
  localparam int IN_W           = 64;
  localparam int BEATS_PER_FEAT = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    SKIP    = 1'b1
  } asm_state_e;

endpackage

// File: rtl/feature_fifo.sv
// Synchronous circular-buffer FIFO with registered occupancy.
// Push and pop in the same cycle are both performed.
module feature_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;

  always_comb begin
    level_d = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/feature_dispatcher.sv
// Assembles 64-bit beats into 256-bit features, queues them and
// issues one feature per cluster fetch, round-robin over the VPEs.
module feature_dispatcher
  import feature_dispatcher_pkg::asm_state_e;
  import feature_dispatcher_pkg::COLLECT;
  import feature_dispatcher_pkg::SKIP;
  import feature_dispatcher_pkg::BEATS_PER_FEAT;
#(
  parameter int IN_W       = 64,
  parameter int FEAT_W     = 256,
  parameter int NUM_VPE    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          rst,
  input  logic                          clk,
  input  logic [IN_W-1:0]               s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  input  logic                          fetch_pkt_feature,
  output logic [FEAT_W-1:0]             pkt_feature,
  output logic [NUM_VPE-1:0]            vpe_mux_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt
);

  localparam int LO_W = (BEATS_PER_FEAT-1)*IN_W;
  localparam int RW   = $clog2(NUM_VPE);
  localparam int CW   = $clog2(NUM_VPE+1);

  asm_state_e        st_q, st_d;
  logic [1:0]        bc_q, bc_d;
  logic [LO_W-1:0]   lo_q;
  logic [15:0]       drop_q;
  logic [CW-1:0]     req_q, req_d;
  logic [RW-1:0]     rr_q;
  logic [FEAT_W-1:0] pkt_q;
  logic [NUM_VPE-1:0] vmv_q;

  logic acc, push, drop, disp;
  logic full, empty;
  logic [FEAT_W-1:0] head;

  assign acc = s_valid && s_ready;

  always_comb begin
    st_d = st_q;
    bc_d = bc_q;
    push = 1'b0;
    drop = 1'b0;
    if (acc) begin
      unique case (st_q)
        COLLECT: begin
          if (bc_q != 2'd3) begin
            if (s_last) begin
              bc_d = 2'd0;
              drop = 1'b1;
            end else begin
              bc_d = bc_q + 2'd1;
            end
          end else begin
            bc_d = 2'd0;
            if (s_last) begin
              push = 1'b1;
            end else begin
              drop = 1'b1;
              st_d = SKIP;
            end
          end
        end
        SKIP: begin
          if (s_last) begin
            st_d = COLLECT;
            bc_d = 2'd0;
          end
        end
        default: st_d = COLLECT;
      endcase
    end
  end

  // A pending request or a same-cycle fetch can be served.
  assign disp = ((req_q != '0) || fetch_pkt_feature) && !empty;

  always_comb begin
    req_d = req_q;
    if (fetch_pkt_feature && !disp) begin
      if (req_q != CW'(NUM_VPE)) req_d = req_q + 1'b1;
    end else if (!fetch_pkt_feature && disp) begin
      req_d = req_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= COLLECT;
      bc_q   <= 2'd0;
      lo_q   <= '0;
      drop_q <= '0;
      req_q  <= '0;
      rr_q   <= '0;
      pkt_q  <= '0;
      vmv_q  <= '0;
    end else begin
      st_q  <= st_d;
      bc_q  <= bc_d;
      req_q <= req_d;
      if (acc && st_q == COLLECT && bc_q != 2'd3)
        lo_q[int'(bc_q)*IN_W +: IN_W] <= s_data;
      if (drop && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      vmv_q <= disp ? (NUM_VPE'(1) << rr_q) : '0;
      if (disp) begin
        pkt_q <= head;
        rr_q  <= (rr_q == RW'(NUM_VPE-1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  feature_fifo #(
    .W     (FEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({s_data, lo_q}),
    .pop_i   (disp),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign s_ready       = !full;
  assign pkt_feature   = pkt_q;
  assign vpe_mux_valid = vmv_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_feature_dispatcher.sv
// Scoreboard bench for feature_dispatcher: table-driven framing
// vectors plus hand-written timing sequences.
module tb_feature_dispatcher;
  import feature_dispatcher_pkg::*;

  localparam int NV = VPE_NUM;
  localparam int FW = FEAT_W;
  localparam int IW = IN_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          fetch = 1'b0;
  logic [FW-1:0] pkt_feature;
  logic [NV-1:0] vpe_mux_valid;
  logic [2:0]    fifo_level;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  feature_dispatcher dut (
    .rst               (rst),
    .clk               (clk),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_last            (s_last),
    .s_ready           (s_ready),
    .fetch_pkt_feature (fetch),
    .pkt_feature       (pkt_feature),
    .vpe_mux_valid     (vpe_mux_valid),
    .fifo_level        (fifo_level),
    .drop_cnt          (drop_cnt)
  );

  typedef struct {
    logic [FW-1:0] feat;
    logic [NV-1:0] oh;
  } exp_t;

  typedef struct {
    int nbeats;
    int seed;
    int exp_drop;
    int exp_level;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   rr_m = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [IW-1:0] beat(int seed, int k);
    logic [7:0] b;
    b = 8'((k + 1) * 17 + seed * 5);
    return {8{b}};
  endfunction

  function automatic logic [FW-1:0] feat(int seed);
    return {beat(seed, 3), beat(seed, 2), beat(seed, 1), beat(seed, 0)};
  endfunction

  // Every strobe must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (!rst && vpe_mux_valid != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", FW'(vpe_mux_valid), '0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_onehot", FW'(vpe_mux_valid), FW'(mon_e.oh));
        chk("sb_feature", pkt_feature, mon_e.feat);
      end
    end
  end

  task automatic send_beat(logic [IW-1:0] d, logic l);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_chk++;
      $display("FAIL s_ready_timeout: got 0 want 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_feat(int seed, int n, bit expect_disp);
    exp_t e;
    if (n == 4 && expect_disp) begin
      e.feat = feat(seed);
      e.oh   = NV'(1) << rr_m;
      sbq.push_back(e);
      rr_m = (rr_m + 1) % NV;
    end
    for (int k = 0; k < n; k++) send_beat(beat(seed, k), k == n - 1);
  endtask

  task automatic fetch_pulse();
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    fetch = 1'b0;
    sbq.delete();
    rr_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{2, 50, 1, 0};
    tbl[1] = '{6, 51, 2, 0};
    tbl[2] = '{4, 52, 2, 1};
    tbl[3] = '{1, 53, 3, 0};
    tbl[4] = '{4, 54, 3, 1};
    tbl[5] = '{5, 55, 4, 0};
    tbl[6] = '{4, 56, 4, 1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", FW'(s_ready), FW'(1));
    chk("rst_pkt", pkt_feature, '0);
    chk("rst_vmv", FW'(vpe_mux_valid), '0);
    chk("rst_level", FW'(fifo_level), '0);
    chk("rst_drop", FW'(drop_cnt), '0);

    // Single feature, single fetch
    send_feat(0, 4, 1);
    chk("t1_level_1", FW'(fifo_level), FW'(1));
    fetch_pulse();
    chk("t1_vmv", FW'(vpe_mux_valid), FW'(8'h01));
    chk("t1_pkt", pkt_feature, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    chk("t1_level_0", FW'(fifo_level), '0);
    @(negedge clk);
    chk("t1_vmv_idle", FW'(vpe_mux_valid), '0);
    chk("t1_pkt_hold", pkt_feature, feat(0));

    // Burst fetch, request saturation, serve-on-push
    do_reset();
    for (int i = 0; i < 4; i++) send_feat(10 + i, 4, 1);
    chk("t2_level_4", FW'(fifo_level), FW'(4));
    chk("t2_full_ready", FW'(s_ready), '0);
    fetch = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("t2_burst", FW'(vpe_mux_valid), (i < 4) ? FW'(1) << i : '0);
    end
    fetch = 1'b0;
    for (int j = 0; j < 8; j++) begin
      send_feat(20 + j, 4, 1);
      chk("t2_push_idle", FW'(vpe_mux_valid), '0);
      @(negedge clk);
      chk("t2_served", FW'(vpe_mux_valid), FW'(1) << ((4 + j) % NV));
    end
    send_feat(40, 4, 0);
    repeat (3) @(negedge clk);
    chk("t2_sat_held", FW'(fifo_level), FW'(1));

    // Framing table: short, long and good features
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_feat(tbl[i].seed, tbl[i].nbeats, 1);
      chk("tbl_drop", FW'(drop_cnt), FW'(tbl[i].exp_drop));
      chk("tbl_level", FW'(fifo_level), FW'(tbl[i].exp_level));
      if (tbl[i].exp_level != 0) begin
        fetch_pulse();
        chk("tbl_drain", FW'(fifo_level), '0);
      end
    end

    // Full FIFO backpressure and simultaneous push/pop
    for (int i = 0; i < 4; i++) send_feat(60 + i, 4, 1);
    chk("t4_level_4", FW'(fifo_level), FW'(4));
    chk("t4_ready_0", FW'(s_ready), '0);
    fetch_pulse();
    chk("t4_ready_1", FW'(s_ready), FW'(1));
    chk("t4_level_3", FW'(fifo_level), FW'(3));
    begin
      exp_t e;
      e.feat = feat(64);
      e.oh   = NV'(1) << rr_m;
      sbq.push_back(e);
      rr_m = (rr_m + 1) % NV;
    end
    for (int k = 0; k < 3; k++) send_beat(beat(64, k), 1'b0);
    fetch = 1'b1;
    send_beat(beat(64, 3), 1'b1);
    fetch = 1'b0;
    chk("t4_pushpop_level", FW'(fifo_level), FW'(3));

    // Asynchronous reset mid-feature with entries queued
    fetch_pulse();
    chk("t5_level_2", FW'(fifo_level), FW'(2));
    send_beat(beat(70, 0), 1'b0);
    send_beat(beat(70, 1), 1'b0);
    #2;
    rst = 1'b1;
    sbq.delete();
    rr_m = 0;
    #1;
    chk("t5_s_ready", FW'(s_ready), FW'(1));
    chk("t5_pkt", pkt_feature, '0);
    chk("t5_vmv", FW'(vpe_mux_valid), '0);
    chk("t5_level", FW'(fifo_level), '0);
    chk("t5_drop", FW'(drop_cnt), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_feat(71, 4, 1);
    fetch_pulse();
    chk("t5_vmv_01", FW'(vpe_mux_valid), FW'(8'h01));
    chk("t5_pkt_new", pkt_feature, feat(71));

    repeat (3) @(negedge clk);
    chk("sb_empty", FW'(sbq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
